// File: rtl/led_sequencer.sv
// Push-button driven LED pattern sequencer: synchronized, debounced key steps
// through OFF/SOLID/SLOW/FAST/CHASE, each pattern paced by a divided tick.
module led_sequencer #(
    parameter int TICK_DIV   = 25000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int NLED       = 8
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic            KEY_N,
    output logic [NLED-1:0] LEDG,
    output logic [2:0]      MODE,
    output logic            TICK
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [TW-1:0]   TICK_MAX   = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]   TICK_ONE   = TW'(1);
    localparam logic [DW-1:0]   DEB_MAX    = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0]   DEB_ONE    = DW'(1);
    localparam logic [NLED-1:0] CHASE_INIT = NLED'(1);

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_SOLID = 3'd1,
        MODE_SLOW  = 3'd2,
        MODE_FAST  = 3'd3,
        MODE_CHASE = 3'd4
    } mode_t;

    logic            sync1_r;
    logic            sync2_r;
    logic            deb_r;
    logic [DW-1:0]   deb_cnt_r;
    logic            press_r;
    mode_t           mode_r;
    mode_t           mode_nxt_s;
    logic [TW-1:0]   tick_cnt_r;
    logic            tick_r;
    logic [1:0]      sub_r;
    logic            phase_r;
    logic [NLED-1:0] chase_r;
    logic [NLED-1:0] ledg_r;

    assign LEDG = ledg_r;
    assign MODE = mode_r;
    assign TICK = tick_r;

    // Two-flop synchronizer for the asynchronous key; idles high (released).
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= KEY_N;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: accept a new level after DEB_CYCLES consecutive differing
    // samples; emit a single press pulse only on the falling (pressed) edge.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            deb_r     <= 1'b1;
            deb_cnt_r <= '0;
            press_r   <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sync2_r == deb_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_MAX) begin
                deb_r     <= sync2_r;
                deb_cnt_r <= '0;
                press_r   <= ~sync2_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end
        end
    end

    // Mode state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_r <= MODE_OFF;
        end else begin
            mode_r <= mode_nxt_s;
        end
    end

    // Mode advance on each press; unused encodings fall back to OFF.
    always_comb begin
        mode_nxt_s = mode_r;
        if (press_r) begin
            case (mode_r)
                MODE_OFF:   mode_nxt_s = MODE_SOLID;
                MODE_SOLID: mode_nxt_s = MODE_SLOW;
                MODE_SLOW:  mode_nxt_s = MODE_FAST;
                MODE_FAST:  mode_nxt_s = MODE_CHASE;
                MODE_CHASE: mode_nxt_s = MODE_OFF;
                default:    mode_nxt_s = MODE_OFF;
            endcase
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    // Tick divider and pattern state. A press restarts the step timing and
    // takes priority over a coinciding tick, so that tick never steps.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_cnt_r <= '0;
            tick_r     <= 1'b0;
            sub_r      <= 2'd0;
            phase_r    <= 1'b0;
            chase_r    <= '0;
        end else if (press_r) begin
            tick_cnt_r <= '0;
            tick_r     <= 1'b0;
            sub_r      <= 2'd0;
            if ((mode_nxt_s == MODE_SLOW) || (mode_nxt_s == MODE_FAST)) begin
                phase_r <= 1'b1;
            end
            if (mode_nxt_s == MODE_CHASE) begin
                chase_r <= CHASE_INIT;
            end
        end else begin
            tick_r     <= (tick_cnt_r == TICK_MAX);
            tick_cnt_r <= (tick_cnt_r == TICK_MAX) ? '0 : (tick_cnt_r + TICK_ONE);
            if (tick_r) begin
                case (mode_r)
                    MODE_SLOW: begin
                        sub_r <= sub_r + 2'd1;
                        if (sub_r == 2'd3) begin
                            phase_r <= ~phase_r;
                        end
                    end
                    MODE_FAST:  phase_r <= ~phase_r;
                    MODE_CHASE: chase_r <= {chase_r[NLED-2:0], chase_r[NLED-1]};
                    default:    begin end
                endcase
            end
        end
    end

    // LED drive, one clock behind mode/phase/chase state.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ledg_r <= '0;
        end else begin
            case (mode_r)
                MODE_OFF:   ledg_r <= '0;
                MODE_SOLID: ledg_r <= '1;
                MODE_SLOW:  ledg_r <= {NLED{phase_r}};
                MODE_FAST:  ledg_r <= {NLED{phase_r}};
                MODE_CHASE: ledg_r <= chase_r;
                default:    ledg_r <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4, DEB_CYCLES=3, NLED=8.
module tb_led_sequencer;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic [7:0] ledg;
    logic [2:0] mode;
    logic       tick;

    int n_checks = 0;
    int n_pass   = 0;

    led_sequencer #(.TICK_DIV(4), .DEB_CYCLES(3), .NLED(8)) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .KEY_N   (key_n),
        .LEDG    (ledg),
        .MODE    (mode),
        .TICK    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // LED value j clocks after entering mode m; steps land one clock after
    // each tick and the LEDs follow one clock later.
    function automatic logic [7:0] exp_led(input int m, input int j);
        int n;
        logic [7:0] one;
        n   = (j >= 2) ? (j - 2) / 4 : 0;
        one = 8'h01;
        case (m)
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return (((n / 4) % 2) == 0) ? 8'hFF : 8'h00;
            3:       return ((n % 2) == 0) ? 8'hFF : 8'h00;
            4:       return one << (n % 8);
            default: return 8'h00;
        endcase
    endfunction

    task automatic press_wait(output int lat);
        logic [2:0] prev;
        prev  = mode;
        key_n = 1'b0;
        lat   = 0;
        while ((mode == prev) && (lat < 20)) begin
            step(1);
            lat++;
        end
        check("press_latency_in_range", ((lat >= 5) && (lat <= 7)) ? 1 : 0, 1);
    endtask

    task automatic observe(input int m, input int ncyc);
        for (int j = 1; j <= ncyc; j++) begin
            step(1);
            check("obs_mode", mode, m);
            check("obs_ledg", ledg, exp_led(m, j));
            check("obs_tick", tick, ((j % 4) == 0) ? 1 : 0);
            if (j == 4) key_n = 1'b1;
        end
    endtask

    initial begin
        int lat;
        int exp_seq [5] = '{1, 2, 3, 4, 0};
        rst_n = 1'b1;
        key_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mode", mode, 0);
        check("rst_ledg", ledg, 0);
        check("rst_tick", tick, 0);
        step(3);
        check("rst_hold_mode", mode, 0);
        rst_n = 1'b1;

        // Idle: nothing lit, tick every fourth clock
        for (int k = 1; k <= 100; k++) begin
            step(1);
            check("idle_mode", mode, 0);
            check("idle_ledg", ledg, 0);
            check("idle_tick", tick, ((k % 4) == 0) ? 1 : 0);
        end

        // Two-clock glitches are rejected
        for (int r = 0; r < 10; r++) begin
            key_n = 1'b0;
            step(2);
            key_n = 1'b1;
            step(4);
            check("glitch_mode", mode, 0);
            check("glitch_ledg", ledg, 0);
        end
        step(6);
        check("glitch_final_mode", mode, 0);

        // Five presses; presses 2..5 are timed so the press coincides with a tick
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(3);
            press_wait(lat);
            check("press_mode", mode, exp_seq[i]);
            check("press_tick_cleared", tick, 0);
            observe(exp_seq[i], 40);
        end

        // Walk to CHASE, then reset with the key held low
        for (int i = 1; i <= 4; i++) begin
            press_wait(lat);
            check("walk_mode", mode, i);
            key_n = 1'b1;
            step(8);
        end
        step(13);
        check("pre_rst_mode", mode, 4);
        key_n = 1'b0;
        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mode", mode, 0);
        check("midrst_ledg", ledg, 0);
        check("midrst_tick", tick, 0);
        step(2);
        rst_n = 1'b1;
        lat = 0;
        while ((mode != 3'd1) && (lat < 10)) begin
            step(1);
            lat++;
        end
        check("rel_mode", mode, 1);
        check("rel_latency_le7", (lat <= 7) ? 1 : 0, 1);
        for (int k = 0; k < 30; k++) begin
            step(1);
            check("held_mode", mode, 1);
        end
        step(1);
        check("held_ledg", ledg, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
